// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
// Instruction-fetch responder. It accepts byte addresses from the program
// counter, reads the addressed word from a synchronous instruction memory,
// and queues {word, pc, err} in a 3-entry FIFO for the decode stage.
// Vectors use big-endian numbering ([0:31], bit 31 = LSB).
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   pc_addr/valid   fetch request from the PC; pc_ready is the accept
//   instr*          FIFO head: word, originating pc, misalign flag, valid
//   instr_ready     decode consumes the head
//   flush           drop every buffered and in-flight fetch
//   ld_en/addr/data instruction memory write port
module imem_fetch_unit #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:31]           pc_addr,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    output logic [0:31]           instr,
    output logic [0:31]           instr_pc,
    output logic                  instr_err,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [0:31]           ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [0:31] mem_q [DEPTH];

    logic [0:31] rd_word_q;
    logic [0:31] rd_pc_q;
    logic        rd_err_q;
    logic        inflight_q;

    logic [0:31] fifo_word_q [3];
    logic [0:31] fifo_pc_q   [3];
    logic        fifo_err_q  [3];

    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic        misalign;
    logic        accept;
    logic        push;
    logic        pop;
    logic        head_vld;
    logic [2:0]  occupancy;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Upper address bits are dropped, so addresses alias modulo the memory size.
    assign rd_idx   = pc_addr[30-DEPTH_LOG2:29];
    assign misalign = pc_addr[30] | pc_addr[31];

    // Ready is computed from registered occupancy only, so decode's ready
    // never reaches the PC combinationally and the FIFO cannot overflow.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign pc_ready  = !rst && !flush && (occupancy < 3'd3);
    assign accept    = pc_valid && pc_ready;

    assign push = inflight_q && !rst && !flush;
    assign pop  = (count_q != 2'd0) && instr_ready && !rst && !flush;

    // Memory write; the read below samples the old word on a same-edge hit.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Read stage
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem_q[rd_idx];
            rd_pc_q   <= pc_addr;
            rd_err_q  <= misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
        end
    end

    // FIFO stage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word_q[wr_ptr_q] <= rd_err_q ? 32'h0 : rd_word_q;
            fifo_pc_q[wr_ptr_q]   <= rd_pc_q;
            fifo_err_q[wr_ptr_q]  <= rd_err_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rst || flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Head presentation; forced to zero when empty or while in reset.
    assign head_vld    = !rst && (count_q != 2'd0);
    assign instr_valid = head_vld;
    assign instr       = head_vld ? fifo_word_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = head_vld ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign instr_err   = head_vld ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic [0:31] instr;
    logic [0:31] instr_pc;
    logic        instr_err;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [0:31] ld_data;

    imem_fetch_unit #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_err(instr_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    // Reference model: memory array, queue of buffered fetches, and the
    // single fetch that has been accepted but not yet buffered.
    logic [31:0] mem_m [256];
    ent_t        sb_q [$];
    bit          infl_m = 0;
    ent_t        infl_e;
    bit          last_accept = 0;
    bit          started = 0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cur_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: inputs are stable between the driver's update (posedge+1)
    // and the next posedge, so compare and advance the model here.
    always @(negedge clk) begin
        if (started) begin
            bit   exp_rdy, exp_vld, acc, pop;
            ent_t h;
            exp_rdy = !rst && !flush && ((sb_q.size() + (infl_m ? 1 : 0)) < 3);
            exp_vld = !rst && (sb_q.size() != 0);
            chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_rdy});
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_vld});
            if (exp_vld) h = sb_q[0];
            else h = '{w: 32'h0, pc: 32'h0, err: 1'b0};
            chk("instr", instr, h.w);
            chk("instr_pc", instr_pc, h.pc);
            chk("instr_err", {31'b0, instr_err}, {31'b0, h.err});

            acc = pc_valid && exp_rdy;
            pop = exp_vld && instr_ready;
            last_accept = acc;
            if (rst || flush) begin
                sb_q.delete();
                infl_m = 0;
            end else begin
                if (pop) void'(sb_q.pop_front());
                if (infl_m) sb_q.push_back(infl_e);
                infl_m = acc;
                if (acc) begin
                    infl_e.pc  = pc_addr;
                    infl_e.err = (pc_addr % 4) != 0;
                    infl_e.w   = infl_e.err ? 32'h0 : mem_m[(pc_addr / 4) % 256];
                end
            end
            if (ld_en) mem_m[ld_addr] = ld_data;
        end
    end

    task automatic drive(input logic r, input logic pv, input logic [31:0] pa,
                         input logic ir, input logic fl, input logic le,
                         input logic [7:0] la, input logic [31:0] ld);
        rst = r; pc_valid = pv; pc_addr = pa; instr_ready = ir;
        flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
        @(posedge clk);
        #1;
        started = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] pa, input logic ir);
        drive(0, 1, pa, ir, 0, 0, 0, 0);
    endtask

    // Stream sequential PCs, advancing only when the last request was taken.
    task automatic stream(input int n, input logic ir);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, cur_pc, ir, 0, 0, 0, 0);
            if (last_accept) cur_pc += 4;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0, 0);

        // Populate the whole memory; words 0..3 get recognisable values.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = (i < 4) ? 32'h11111111 * (i + 1) : $urandom;
            drive(0, 0, 0, 1, 0, 1, 8'(i), v);
        end
        idle(2);

        // Back-to-back fetches with decode always ready.
        fetch(32'h0, 1); fetch(32'h4, 1); fetch(32'h8, 1); fetch(32'hC, 1);
        idle(4);

        // Stall with decode held off, then release and keep streaming.
        cur_pc = 0;
        stream(6, 0);
        stream(10, 1);
        idle(4);

        // Misaligned fetch followed by an aligned one.
        fetch(32'h6, 1); fetch(32'h8, 1);
        idle(4);

        // Two buffered plus one in flight, then a one-cycle flush.
        fetch(32'h0, 0); fetch(32'h4, 0); fetch(32'h8, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        fetch(32'h40, 1);
        idle(4);

        // Load and fetch of the same word on one edge, refetch, alias.
        drive(0, 1, 32'h14, 1, 0, 1, 8'd5, 32'hDEADBEEF);
        fetch(32'h14, 1);
        fetch(32'h414, 1);
        idle(4);

        // Mid-stream reset with three outstanding; memory must survive.
        cur_pc = 0;
        stream(4, 0);
        drive(1, 1, 32'h0, 0, 0, 0, 0, 0);
        fetch(32'h0, 1);
        idle(4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pa;
            pa = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  pa,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) == 0),
                  8'($urandom),
                  $urandom);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Instruction-fetch responder that consumes the byte addresses issued by the 32-bit program counter and returns the addressed 32-bit instruction words to the decode stage. It holds a word-addressed synchronous instruction memory, loaded through a dedicated write port. It performs one read per accepted address and buffers results in a 3-entry output FIFO, so that decode back-pressure stalls the program counter without losing or duplicating instructions. Bit numbering is big-endian throughout ([0:31], bit 31 = LSB).

## Interface
Parameters:
- DEPTH_LOG2, default 8: instruction memory depth is 2^DEPTH_LOG2 words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_addr  in  [0:31]  byte address from program counter.
- pc_valid  in  1  pc_addr is a valid fetch request.
- pc_ready  out  1  unit accepts a request this cycle.
- instr  out  [0:31]  instruction word at FIFO head.
- instr_pc  out  [0:31]  pc_addr that produced instr.
- instr_err  out  1  head entry came from a misaligned address.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes head this cycle.
- flush  in  1  discard all buffered and in-flight fetches (branch redirect).
- ld_en  in  1  memory write enable.
- ld_addr  in  [DEPTH_LOG2-1:0]  memory word index to write.
- ld_data  in  [0:31]  word to write.

## Operation
- Accept: a request is accepted on an edge where pc_valid && pc_ready.
- Word index: pc_addr[30-DEPTH_LOG2:29]. Byte-offset bits are [30:31]. Bits [0:29-DEPTH_LOG2] are ignored, so addresses alias modulo 2^(DEPTH_LOG2+2).
- Read stage: on the accept edge, register mem[index], pc_addr, misalign flag (pc_addr[30:31] != 0), and set inflight=1. Otherwise inflight=0.
- FIFO stage: an edge with inflight=1 pushes {word, pc, err} into the 3-entry FIFO. Misaligned entries push instr=32'h0 with err=1.
- Pop: an edge with instr_valid && instr_ready removes the head. Push and pop on the same edge are both honoured; count is unchanged.
- pc_ready = !rst && !flush && (count + inflight < 3). It depends only on registers and rst/flush; there is no combinational path from instr_ready. This guarantees the FIFO never overflows.
- instr_valid = (count != 0). instr/instr_pc/instr_err show the head entry, or 0 when the FIFO is empty.
- Ordering: entries are delivered strictly in accept order; none are dropped except by flush/rst.
- flush: at the edge it is sampled, count←0 and inflight←0, and pc_valid is ignored that cycle. A pop on the same edge is discarded as part of the flush.
- Load port: an ld_en edge writes mem[ld_addr]←ld_data. A read of the same index on the same edge returns the old word (read-before-write).
- Reset: count=0, inflight=0, FIFO pointers 0. Memory contents are not reset. rst has priority over flush.

## Timing
- Outputs during and immediately after the rst edge: instr_valid=0, instr=0, instr_pc=0, instr_err=0, pc_ready=0 while rst=1. pc_ready=1 in the first cycle after rst deasserts.
- Latency: request accepted at edge E; instr_valid=1 with that word after edge E+1 (visible in cycle E+1 to E+2).
- Throughput: 1 instruction/cycle sustained with pc_valid=1 and instr_ready=1.
- Stall: with instr_ready=0, at most 3 accepts complete; pc_ready falls once count+inflight=3. After the first pop, pc_ready is 1 again in the cycle following that edge.
- Flush-to-ready: pc_ready=1 in the cycle after flush deasserts; the first post-flush instruction appears 2 edges after its accept.
- Mid-operation rst behaves identically to flush plus output zeroing; no partially-written entry survives.

## Test plan
- Load mem[0..3]=32'h11111111..32'h44444444; issue PC 0,4,8,12 back-to-back with instr_ready=1 -> instr_valid from 2nd edge, 4 consecutive words in order with instr_pc=0,4,8,12, instr_err=0.
- Hold instr_ready=0, pc_valid=1 streaming from 0 -> exactly 3 accepts, pc_ready=0 thereafter, FIFO holds words 0..2. Release instr_ready -> words delivered in order, then stream resumes at PC 12 with no gap or duplicate.
- pc_addr=32'h00000006 -> entry instr=0, instr_err=1, instr_pc=6. The following aligned PC 8 returns mem[2] with err=0.
- Two entries buffered plus one inflight; assert flush with instr_ready=1 for one cycle -> next cycle instr_valid=0, pc_ready=1. New PC 32'h40 returns mem[16] after 2 edges.
- With DEPTH_LOG2=8: ld_en writing mem[5]=32'hDEADBEEF on the same edge as accepting PC 20 -> old mem[5] is returned. A re-fetch of PC 20 -> 32'hDEADBEEF. Fetch of PC 32'h00000414 aliases to mem[5].
- Assert rst for one cycle mid-stream with 3 entries outstanding -> all outputs 0 and pc_ready=0 during rst. Memory is preserved: a refetch of PC 0 returns 32'h11111111.
